axi4_lite_slave_regs: RTL and testbench

AXI4-Lite slave (responder) exposing a bank of NUM_REGS 32-bit read/write registers. It is the target-side counterpart of axi4_master and is used as the bench target for that bridge and as a control/status register block in fabric designs.
- AW, W and AR channels are accepted independently.
- Writes are byte-strobed.
- Out-of-range accesses complete with SLVERR.
- Register contents are exported as a flat vector to surrounding logic.

---
 rtl/axi4_lite_pkg.sv | 27 ++
 rtl/axi4_lite_slave_regs.sv | 112 +++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: AXI4-Lite response codes and shared address/strobe helpers
package axi4_lite_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
      logic [31:0] m;
      m = old_v;
      for (int b = 0; b < 4; b++)
         if (strb[b]) m[8*b +: 8] = new_v[8*b +: 8];
      return m;
   endfunction

   function automatic logic in_range(input logic [63:0] addr, input int unsigned num_regs);
      return addr < 64'(num_regs) * 64'd4;
   endfunction

   // num_regs is a power of two, so the word index wraps with a mask
   function automatic int unsigned reg_index(input logic [63:0] addr, input int unsigned num_regs);
      return int'(addr[33:2]) & (num_regs - 1);
   endfunction

endpackage

// File: rtl/axi4_lite_slave_regs.sv
// axi4_lite_slave_regs: AXI4-Lite responder over a bank of byte-strobed 32-bit registers
module axi4_lite_slave_regs
   import axi4_lite_pkg::*;
#(
   parameter int          AXI_DEPTH = 32,
   parameter int          AXI_WIDTH = 32,
   parameter int          NUM_REGS  = 16,
   parameter logic [31:0] RESET_VAL = 32'h0
) (
   input  logic                     s_axi_aclk,
   input  logic                     s_axi_aresetn,
   input  logic                     s_axi_awvalid,
   output logic                     s_axi_awready,
   input  logic [AXI_DEPTH-1:0]     s_axi_awaddr,
   input  logic                     s_axi_wvalid,
   output logic                     s_axi_wready,
   input  logic [AXI_WIDTH-1:0]     s_axi_wdata,
   input  logic [3:0]               s_axi_wstrb,
   output logic                     s_axi_bvalid,
   input  logic                     s_axi_bready,
   output logic [1:0]               s_axi_bresp,
   input  logic                     s_axi_arvalid,
   output logic                     s_axi_arready,
   input  logic [AXI_DEPTH-1:0]     s_axi_araddr,
   output logic                     s_axi_rvalid,
   input  logic                     s_axi_rready,
   output logic [AXI_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]               s_axi_rresp,
   output logic [NUM_REGS*32-1:0]   regs_o,
   output logic [NUM_REGS-1:0]      wr_pulse_o
);

   localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

   logic                 ready_en, aw_full, w_full;
   logic [AXI_DEPTH-1:0] aw_addr_q;
   logic [AXI_WIDTH-1:0] w_data_q;
   logic [3:0]           w_strb_q;
   logic [31:0]          regs_q [NUM_REGS];
   resp_t                bresp_q, rresp_q;
   logic [IDX_W-1:0]     w_idx, r_idx;
   logic                 w_ok, r_ok;

   assign w_ok  = in_range(64'(aw_addr_q), NUM_REGS);
   assign r_ok  = in_range(64'(s_axi_araddr), NUM_REGS);
   assign w_idx = IDX_W'(reg_index(64'(aw_addr_q), NUM_REGS));
   assign r_idx = IDX_W'(reg_index(64'(s_axi_araddr), NUM_REGS));

   assign s_axi_awready = ready_en & ~aw_full;
   assign s_axi_wready  = ready_en & ~w_full;
   assign s_axi_arready = ready_en & ~s_axi_rvalid;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rresp   = rresp_q;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_export
      assign regs_o[32*i +: 32] = regs_q[i];
   end

   // Write channel: AW and W park independently; commit once both are held and B is free
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         ready_en     <= 1'b0;
         aw_full      <= 1'b0;
         w_full       <= 1'b0;
         aw_addr_q    <= '0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         s_axi_bvalid <= 1'b0;
         bresp_q      <= RESP_OKAY;
         wr_pulse_o   <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      end else begin
         ready_en   <= 1'b1;
         wr_pulse_o <= '0;
         if (s_axi_awvalid && s_axi_awready) begin
            aw_full   <= 1'b1;
            aw_addr_q <= s_axi_awaddr;
         end
         if (s_axi_wvalid && s_axi_wready) begin
            w_full   <= 1'b1;
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
         end
         if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
         if (aw_full && w_full && !s_axi_bvalid) begin
            s_axi_bvalid <= 1'b1;
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            bresp_q      <= w_ok ? RESP_OKAY : RESP_SLVERR;
            if (w_ok) begin
               regs_q[w_idx]     <= byte_merge(regs_q[w_idx], w_data_q, w_strb_q);
               wr_pulse_o[w_idx] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
         rresp_q      <= RESP_OKAY;
      end else if (s_axi_arvalid && s_axi_arready) begin
         s_axi_rvalid <= 1'b1;
         s_axi_rdata  <= r_ok ? regs_q[r_idx] : '0;
         rresp_q      <= r_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_rvalid && s_axi_rready) begin
         s_axi_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// tb_axi4_lite_slave_regs: directed vector table plus corner-case sequences for the register slave
module tb_axi4_lite_slave_regs;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready;
   logic [31:0]  awaddr, wdata, araddr, rdata;
   logic [3:0]   wstrb;
   logic [1:0]   bresp, rresp;
   logic [511:0] regs;
   logic [15:0]  pulse;

   int n_checks = 0;
   int n_fail   = 0;

   axi4_lite_slave_regs dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
      .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
      .regs_o(regs), .wr_pulse_o(pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [15:0] pulse;
   } vec_t;

   vec_t tbl [11];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] reg_at(input int i);
      return regs[32*i +: 32];
   endfunction

   task automatic do_write(input string nm, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er, input logic [15:0] ep);
      logic ha, hw;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
         ha = awready; hw = wready;
         tick();
         if (ha) awvalid = 1'b0;
         if (hw) wvalid = 1'b0;
      end
      chk({nm, "_accept"}, 64'(awvalid | wvalid), 64'd0);
      awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < 20 && !bvalid; i++) tick();
      chk({nm, "_bvalid"}, 64'(bvalid), 64'd1);
      chk({nm, "_bresp"}, 64'(bresp), 64'(er));
      chk({nm, "_pulse"}, 64'(pulse), 64'(ep));
      if (bready) tick();
   endtask

   task automatic do_read(input string nm, input logic [31:0] a, input logic [31:0] ed,
                          input logic [1:0] er);
      logic ha;
      araddr = a; arvalid = 1'b1;
      for (int i = 0; i < 20 && arvalid; i++) begin
         ha = arready;
         tick();
         if (ha) arvalid = 1'b0;
      end
      chk({nm, "_accept"}, 64'(arvalid), 64'd0);
      arvalid = 1'b0;
      chk({nm, "_rvalid"}, 64'(rvalid), 64'd1);
      chk({nm, "_rdata"}, 64'(rdata), 64'(ed));
      chk({nm, "_rresp"}, 64'(rresp), 64'(er));
      tick();
   endtask

   initial begin
      tbl[0]  = '{1'b1, 32'h04, 32'h12345678, 4'hF, 2'b00, 16'h0002};
      tbl[1]  = '{1'b0, 32'h04, 32'h12345678, 4'h0, 2'b00, 16'h0000};
      tbl[2]  = '{1'b1, 32'h05, 32'hAABBCCDD, 4'h3, 2'b00, 16'h0002};
      tbl[3]  = '{1'b0, 32'h06, 32'h1234CCDD, 4'h0, 2'b00, 16'h0000};
      tbl[4]  = '{1'b1, 32'h3C, 32'hCAFEF00D, 4'hF, 2'b00, 16'h8000};
      tbl[5]  = '{1'b0, 32'h3C, 32'hCAFEF00D, 4'h0, 2'b00, 16'h0000};
      tbl[6]  = '{1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 2'b10, 16'h0000};
      tbl[7]  = '{1'b0, 32'h40, 32'h00000000, 4'h0, 2'b10, 16'h0000};
      tbl[8]  = '{1'b1, 32'h3C, 32'h00000000, 4'h0, 2'b00, 16'h8000};
      tbl[9]  = '{1'b0, 32'h3C, 32'hCAFEF00D, 4'h0, 2'b00, 16'h0000};
      tbl[10] = '{1'b0, 32'hFFFFFFFC, 32'h00000000, 4'h0, 2'b10, 16'h0000};

      rst_n = 1'b0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
      tick(); tick();
      chk("rst_readies", 64'({awready, wready, arready}), 64'd0);
      chk("rst_valids", 64'({bvalid, rvalid}), 64'd0);
      chk("rst_resp_data", 64'({bresp, rresp, rdata}), 64'd0);
      chk("rst_pulse", 64'(pulse), 64'd0);
      chk("rst_regs", 64'(regs != '0), 64'd0);
      rst_n = 1'b1;
      chk("rel_readies_low", 64'({awready, wready, arready}), 64'd0);
      tick();
      chk("rel_readies_high", 64'({awready, wready, arready}), 64'd7);

      // same-cycle AW/W: bvalid and pulse one edge after the handshake
      awaddr = 32'h08; wdata = 32'hDEADBEAF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      tick();
      awvalid = 0; wvalid = 0;
      tick();
      chk("t1_bvalid", 64'(bvalid), 64'd1);
      chk("t1_bresp", 64'(bresp), 64'd0);
      chk("t1_pulse", 64'(pulse), 64'h0004);
      chk("t1_reg2", 64'(reg_at(2)), 64'hDEADBEAF);
      tick();
      chk("t1_pulse_gone", 64'(pulse), 64'd0);
      chk("t1_b_done", 64'(bvalid), 64'd0);

      // W three cycles ahead of AW
      wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
      chk("t2_wready", 64'(wready), 64'd1);
      tick();
      wvalid = 0;
      for (int i = 0; i < 3; i++) begin
         chk("t2_wready_held_low", 64'(wready), 64'd0);
         chk("t2_no_b", 64'(bvalid), 64'd0);
         tick();
      end
      awaddr = 32'h08; awvalid = 1;
      tick();
      awvalid = 0;
      tick();
      chk("t2_bvalid", 64'(bvalid), 64'd1);
      chk("t2_bresp", 64'(bresp), 64'd0);
      chk("t2_reg2", 64'(reg_at(2)), 64'hDE22BE44);
      chk("t2_wready_back", 64'(wready), 64'd1);
      tick();

      for (int v = 0; v < 11; v++) begin
         if (tbl[v].wr) do_write($sformatf("vec%0d", v), tbl[v].addr, tbl[v].data, tbl[v].strb,
                                 tbl[v].resp, tbl[v].pulse);
         else do_read($sformatf("vec%0d", v), tbl[v].addr, tbl[v].data, tbl[v].resp);
      end
      chk("tbl_reg0", 64'(reg_at(0)), 64'd0);
      chk("tbl_reg1", 64'(reg_at(1)), 64'h1234CCDD);
      chk("tbl_reg2", 64'(reg_at(2)), 64'hDE22BE44);
      chk("tbl_reg15", 64'(reg_at(15)), 64'hCAFEF00D);

      // read held off by rready
      rready = 0; araddr = 32'h08; arvalid = 1;
      chk("t4_arready", 64'(arready), 64'd1);
      tick();
      arvalid = 0;
      for (int i = 0; i < 5; i++) begin
         chk("t4_rvalid_held", 64'(rvalid), 64'd1);
         chk("t4_rdata_held", 64'(rdata), 64'hDE22BE44);
         chk("t4_arready_low", 64'(arready), 64'd0);
         tick();
      end
      rready = 1;
      tick();
      chk("t4_r_done", 64'(rvalid), 64'd0);

      // read and write commit to reg3 at the same edge: old value returned
      awaddr = 32'h0C; wdata = 32'h55667788; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      tick();
      awvalid = 0; wvalid = 0; araddr = 32'h0C; arvalid = 1;
      tick();
      arvalid = 0;
      chk("t5_bvalid", 64'(bvalid), 64'd1);
      chk("t5_rvalid", 64'(rvalid), 64'd1);
      chk("t5_rdata_old", 64'(rdata), 64'd0);
      chk("t5_reg3", 64'(reg_at(3)), 64'h55667788);
      tick();
      do_read("t5_reread", 32'h0C, 32'h55667788, 2'b00);

      // reset while B is pending
      bready = 0;
      do_write("t6_wr", 32'h10, 32'h0BADF00D, 4'hF, 2'b00, 16'h0010);
      chk("t6_b_pending", 64'(bvalid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_bvalid_drop", 64'(bvalid), 64'd0);
      chk("t6_regs_clear", 64'(regs != '0), 64'd0);
      chk("t6_readies_low", 64'({awready, wready, arready}), 64'd0);
      bready = 1;
      tick(); tick();
      chk("t6_readies_in_rst", 64'({awready, wready, arready}), 64'd0);
      rst_n = 1'b1;
      chk("t6_readies_after_rel", 64'({awready, wready, arready}), 64'd0);
      tick();
      chk("t6_readies_up", 64'({awready, wready, arready}), 64'd7);
      do_read("t6_reg4", 32'h10, 32'h0, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
